// File: rtl/lpif_csr_avmm_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lpif_csr_avmm_arb
// Brief    : Round-robin two-requester Avalon-MM arbiter for the CSR bridge,
//            one outstanding transaction, with read-response timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lpif_csr_avmm_arb #(
    parameter int unsigned RD_TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    input  logic        s_readdatavalid,
    output logic        grant_id,
    output logic        busy,
    output logic        rd_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout = 16'(RD_TIMEOUT);

    state_t      r_state;
    logic        r_rr_ptr;
    logic        r_grant_id;
    logic        r_err;
    logic [15:0] r_cnt;

    logic        w_req0;
    logic        w_req1;
    logic        w_sel;
    logic        w_gnt_read;
    logic        w_gnt_write;
    logic        w_in_grant;
    logic        w_in_wait;
    logic        w_cnt_hit;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;

    assign w_req0      = m0_read | m0_write;
    assign w_req1      = m1_read | m1_write;
    assign w_sel       = (w_req0 & w_req1) ? r_rr_ptr : w_req1;
    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_in_wait   = (r_state == ST_RD_WAIT);

    // Read has priority when a requester raises both strobes.
    assign w_gnt_read  = r_grant_id ? m1_read : m0_read;
    assign w_gnt_write = (r_grant_id ? m1_write : m0_write) & ~w_gnt_read;

    assign s_read       = w_in_grant & w_gnt_read;
    assign s_write      = w_in_grant & w_gnt_write;
    assign s_address    = w_in_grant ? (r_grant_id ? m1_address    : m0_address)    : '0;
    assign s_writedata  = w_in_grant ? (r_grant_id ? m1_writedata  : m0_writedata)  : '0;
    assign s_byteenable = w_in_grant ? (r_grant_id ? m1_byteenable : m0_byteenable) : '0;

    // Real data on the timeout cycle takes precedence over the error response.
    assign w_cnt_hit   = (r_cnt >= c_timeout);
    assign w_rsp_valid = w_in_wait & (s_readdatavalid | w_cnt_hit);
    assign w_rsp_data  = s_readdatavalid ? s_readdata : ERR_DATA;

    assign m0_waitrequest   = ~(w_in_grant & ~r_grant_id) | s_waitrequest;
    assign m1_waitrequest   = ~(w_in_grant &  r_grant_id) | s_waitrequest;
    assign m0_readdatavalid = w_rsp_valid & ~r_grant_id;
    assign m1_readdatavalid = w_rsp_valid &  r_grant_id;
    assign m0_readdata      = m0_readdatavalid ? w_rsp_data : '0;
    assign m1_readdata      = m1_readdatavalid ? w_rsp_data : '0;

    assign grant_id       = r_grant_id;
    assign busy           = (r_state != ST_IDLE);
    assign rd_timeout_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 1'b0;
            r_grant_id <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant_id <= w_sel;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Requester withdrew before acceptance: nothing was issued.
                    if (!(w_gnt_read | w_gnt_write)) begin
                        r_state <= ST_IDLE;
                    end else if (!s_waitrequest) begin
                        if (w_gnt_read) begin
                            r_state <= ST_RD_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= ~r_grant_id;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (w_rsp_valid) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= ~r_grant_id;
                        if (!s_readdatavalid) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
